inst_issue: RTL

Instruction sequencer that feeds the PE-array instruction decoder. It holds a small program of 8-bit instruction words and issues one opcode per clock on `inst_v`/`opcode`, expanding per-entry repeat counts and honouring a stall input. After the last issue it waits out the decoder pipeline, then pulses `done` in the same cycle the decoder raises `dout_v` for the final instruction. It sits between the host/load path and the per-PE control blocks.

---
 rtl/inst_issue_pkg.sv | 28 ++
 rtl/inst_buf.sv | 26 ++
 rtl/inst_issue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/inst_issue_pkg.sv
// inst_issue_pkg: opcode constants, instruction field layout and FSM state encodings
// shared by inst_issue and its instruction buffer.
package inst_issue_pkg;

   localparam int INST_WIDTH = 8;
   localparam int OP_MSB     = 7;
   localparam int OP_LSB     = 5;
   localparam int REP_MSB    = 4;
   localparam int REP_LSB    = 0;

   localparam logic [2:0] OP_LOAD   = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_MUL    = 3'b100;
   localparam logic [2:0] OP_MULADD = 3'b101;
   localparam logic [2:0] OP_MULSUB = 3'b110;
   localparam logic [2:0] OP_MAX    = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [OP_MSB-OP_LSB:0]   op;
      logic [REP_MSB-REP_LSB:0] rep;
   } inst_t;

endpackage

// File: rtl/inst_buf.sv
// inst_buf: DEPTH x 8 program store, synchronous write and combinational read, no reset.
module inst_buf
   import inst_issue_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [INST_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [INST_WIDTH-1:0] o_rd_data
);

   logic [INST_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/inst_issue.sv
// inst_issue: issues one opcode per cycle from a small program, then waits out the decoder
// latency and pulses done. Defining ISSUE_LOOP_EN adds a `loop` input that restarts the program.
module inst_issue
   import inst_issue_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DELAY      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  prog_v,
   input  logic [INST_WIDTH-1:0] prog_inst,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  stall,
`ifdef ISSUE_LOOP_EN
   input  logic                  loop,
`endif
   output logic                  inst_v,
   output logic [2:0]            opcode,
   output logic                  busy,
   output logic                  done,
   output logic                  prog_full
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam int DRN_W = $clog2(DELAY);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(DELAY - 1);

   logic [1:0]            r_state, w_state;
   logic [CNT_W-1:0]      r_count, w_count;
   logic [ADDR_WIDTH-1:0] r_rd_ptr, w_rd_ptr;
   logic [4:0]            r_iss, w_iss;
   logic [DRN_W-1:0]      r_drain, w_drain;
   logic                  r_inst_v, w_inst_v;
   logic [2:0]            r_opcode, w_opcode;
   logic                  r_busy, r_done, w_done, r_full;
   logic                  w_wr_en, w_last;
   logic [INST_WIDTH-1:0] w_rd_data;
   inst_t                 w_cur;

   inst_buf #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_inst_buf (
      .i_clk     (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_count[ADDR_WIDTH-1:0]),
      .i_wr_data (prog_inst),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   assign w_cur  = inst_t'(w_rd_data);
   assign w_last = (CNT_W'(r_rd_ptr) + CNT_W'(1)) == r_count;

   // r_iss counts issues already made from the current entry; the entry is finished
   // once it reaches that entry's repeat field.
   always_comb begin
      w_state  = r_state;
      w_count  = r_count;
      w_rd_ptr = r_rd_ptr;
      w_iss    = r_iss;
      w_drain  = r_drain;
      w_inst_v = 1'b0;
      w_opcode = OP_LOAD;
      w_done   = 1'b0;
      w_wr_en  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (r_count == '0) begin
                  w_done = 1'b1;
               end else begin
                  w_state  = ST_RUN;
                  w_rd_ptr = '0;
                  w_iss    = '0;
               end
            end else if (clear) begin
               w_count = '0;
            end else if (prog_v && (r_count != FULL_CNT)) begin
               w_wr_en = 1'b1;
               w_count = r_count + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!stall) begin
               w_inst_v = 1'b1;
               w_opcode = w_cur.op;
               if (r_iss != w_cur.rep) begin
                  w_iss = r_iss + 5'd1;
               end else begin
                  w_iss = '0;
                  if (!w_last) begin
                     w_rd_ptr = r_rd_ptr + ADDR_WIDTH'(1);
                  end else begin
`ifdef ISSUE_LOOP_EN
                     if (loop) begin
                        w_rd_ptr = '0;
                     end else begin
                        w_state = ST_DRAIN;
                        w_drain = DRAIN_INIT;
                     end
`else
                     w_state = ST_DRAIN;
                     w_drain = DRAIN_INIT;
`endif
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (r_drain == '0) begin
               w_done  = 1'b1;
               w_state = ST_IDLE;
            end else begin
               w_drain = r_drain - DRN_W'(1);
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_iss    <= '0;
         r_drain  <= '0;
         r_inst_v <= 1'b0;
         r_opcode <= OP_LOAD;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_full   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_count  <= w_count;
         r_rd_ptr <= w_rd_ptr;
         r_iss    <= w_iss;
         r_drain  <= w_drain;
         r_inst_v <= w_inst_v;
         r_opcode <= w_opcode;
         r_busy   <= (w_state != ST_IDLE);
         r_done   <= w_done;
         r_full   <= (w_count == FULL_CNT);
      end
   end

   assign inst_v    = r_inst_v;
   assign opcode    = r_opcode;
   assign busy      = r_busy;
   assign done      = r_done;
   assign prog_full = r_full;

endmodule
